sram_byte_bridge: RTL
=====================

Name: sram_byte_bridge

Overview:
- Sits between the 8-bit SoC external bus (19-bit byte address, byte read/write) and the 16-bit SRAM word controller (18-bit word address, 16-bit data, no byte enables).
- Converts byte reads into word reads with lane select.
- Converts byte writes into read-modify-write word cycles.
- Holds a one-word write-through cache to skip SRAM reads on repeated access to the same word.
- Gives the CPU a ready pulse and flags SRAM timeouts.

Parameters:
- ADDR_W, 19: byte address width. Word address width is ADDR_W-1.
- CACHE_EN, 1: 1 enables the one-word cache; 0 forces every access to SRAM.
- TIMEOUT, 255: maximum cycles to wait for mem_ready before aborting. Range 1..1023.

Ports:
- clk  in  1  system clock (bridge and SRAM controller domain).
- reset_n  in  1  asynchronous, active-low reset.
- bus_addr  in  ADDR_W  byte address. bit0 selects the lane: 0 = [7:0], 1 = [15:8].
- bus_do  in  8  write data from the CPU.
- bus_read  in  1  read request level. Held until bus_ready.
- bus_write  in  1  write request level. Held until bus_ready.
- bus_di  out  8  read data to the CPU. Registered.
- bus_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  sticky timeout flag. Cleared only by reset.
- mem_address  out  ADDR_W-1  SRAM word address.
- mem_data_write  out  16  word to write.
- mem_data_read  in  16  word read. Valid when mem_ready=1 after a read.
- mem_read  out  1  one-cycle read strobe.
- mem_write  out  1  one-cycle write strobe.
- mem_ready  in  1  one-cycle completion pulse from the SRAM controller.

Behaviour:
- Reset values (async assert):
  - bus_di=0, bus_ready=0, bus_err=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_data_write=0.
  - Cache valid=0, cache tag=0, cache data=0.
  - State=IDLE, timeout counter=0.
- Deassertion is synchronous to clk through a two-flop synchroniser.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, GUARD.
- IDLE, request sampled at cycle N:
  - If bus_write and bus_read are both 1, the write wins.
  - Read hit (CACHE_EN, valid, tag==bus_addr[ADDR_W-1:1]): bus_di=selected cache byte and bus_ready=1 at N+1. Next state GUARD.
  - Read miss: mem_read=1 and mem_address=word address at N+1. Next state RD_WAIT.
  - Write hit: merged word goes to the cache and mem_data_write; mem_write=1 at N+1. Next state RMW_WR.
  - Write miss: mem_read=1 at N+1. Next state RMW_RD.
- RD_WAIT, on mem_ready:
  - Latch mem_data_read into the cache and set valid.
  - Present the selected byte on bus_di and pulse bus_ready in the next cycle.
  - Next state GUARD.
- RMW_RD, on mem_ready:
  - Merge bus_do into the addressed lane of mem_data_read; keep the other lane.
  - Update the cache.
  - mem_write=1 with the merged word in the next cycle. Next state RMW_WR.
- RMW_WR, on mem_ready: bus_ready=1 in the next cycle. Next state GUARD.
- GUARD: exactly one cycle. Requests are ignored. Next state IDLE. The requestor must drop its request by the GUARD cycle.
- Request inputs are sampled only in IDLE. Address and data changes while busy are ignored; the values latched at acceptance are used.
- Timeout:
  - The counter clears on each strobe and increments every cycle in a wait state.
  - On reaching TIMEOUT: set bus_err, invalidate the cache, bus_di=8'hFF, pulse bus_ready, go to GUARD.
  - Write-miss timeout: no mem_write is issued.
- mem_ready in IDLE or GUARD is ignored.
- mem_read and mem_write are never high in the same cycle. At most one SRAM access is outstanding.
- CACHE_EN=0: every read misses and every write goes through RMW_RD.
- Reset mid-operation: everything returns to reset values immediately. The cache is invalid after reset.

Test Plan:
- Read miss at 0x00001, SRAM returns 16'hBEEF after 3 cycles -> one mem_read at word 0x00000; bus_di=8'hBE with bus_ready 1 cycle after mem_ready.
- Read hit at 0x00000 right after that -> no mem_read; bus_di=8'hEF with bus_ready 1 cycle after request.
- Write 8'h12 to 0x00041, SRAM word 0x00020 holds 16'hAB34 -> mem_read, then mem_write of 16'h1234 to 0x00020, then bus_ready.
- Write hit 8'h77 to 0x00040 after that -> no mem_read; mem_write of 16'h1277.
- Read with mem_ready never asserted, TIMEOUT=8 -> bus_ready after 8 wait cycles; bus_di=8'hFF, bus_err=1; next read to the same word misses.
- bus_read and bus_write both high, then reset_n pulled low during RMW_RD -> write path taken; on reset all outputs go to 0 asynchronously and the next access misses.

Source files
------------

// File: rtl/sram_byte_bridge_if.sv
// rtl/sram_byte_bridge_if.sv - CPU byte bus and SRAM word-controller signals of the byte bridge
interface sram_byte_bridge_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_do;
  logic              bus_read;
  logic              bus_write;
  logic [7:0]        bus_di;
  logic              bus_ready;
  logic              bus_err;
  logic [ADDR_W-2:0] mem_address;
  logic [15:0]       mem_data_write;
  logic [15:0]       mem_data_read;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;

  // master: the bridge itself (answers the CPU, drives the SRAM controller)
  modport master (
    input  bus_addr, bus_do, bus_read, bus_write, mem_data_read, mem_ready,
    output bus_di, bus_ready, bus_err, mem_address, mem_data_write, mem_read, mem_write
  );

  modport slave (
    output bus_addr, bus_do, bus_read, bus_write, mem_data_read, mem_ready,
    input  bus_di, bus_ready, bus_err, mem_address, mem_data_write, mem_read, mem_write
  );
endinterface

// File: rtl/sram_byte_bridge.sv
// rtl/sram_byte_bridge.sv - 8-bit bus to 16-bit SRAM bridge with RMW writes and one-word cache
module sram_byte_bridge #(
  parameter int ADDR_W   = 19,
  parameter int CACHE_EN = 1,
  parameter int TIMEOUT  = 255
) (
  input logic                clk,
  input logic                reset_n,
  sram_byte_bridge_if.master bif
);
  localparam int WA_W = ADDR_W - 1;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RMW_RD  = 3'd2;
  localparam logic [2:0] RMW_WR  = 3'd3;
  localparam logic [2:0] GUARD   = 3'd4;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [2:0]      state;
  logic [9:0]      tcnt;
  logic            lane;
  logic [7:0]      wbyte;
  logic            cache_valid;
  logic [WA_W-1:0] cache_tag;
  logic [15:0]     cache_data;
  logic [WA_W-1:0] req_word;
  logic            req_lane;
  logic            hit;
  logic            waiting;

  // reset asserts immediately, releases two clocks after reset_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign req_word = bif.bus_addr[ADDR_W-1:1];
  assign req_lane = bif.bus_addr[0];
  assign hit      = (CACHE_EN != 0) && cache_valid && (cache_tag == req_word);
  assign waiting  = (state == RD_WAIT) || (state == RMW_RD) || (state == RMW_WR);

  function automatic logic [15:0] merge(input logic [15:0] w, input logic ln, input logic [7:0] b);
    return ln ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] w, input logic ln);
    return ln ? w[15:8] : w[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      tcnt               <= '0;
      lane               <= 1'b0;
      wbyte              <= '0;
      cache_valid        <= 1'b0;
      cache_tag          <= '0;
      cache_data         <= '0;
      bif.bus_di         <= '0;
      bif.bus_ready      <= 1'b0;
      bif.bus_err        <= 1'b0;
      bif.mem_address    <= '0;
      bif.mem_data_write <= '0;
      bif.mem_read       <= 1'b0;
      bif.mem_write      <= 1'b0;
    end else begin
      bif.bus_ready <= 1'b0;
      bif.mem_read  <= 1'b0;
      bif.mem_write <= 1'b0;
      if (waiting && !bif.mem_ready) begin
        if (tcnt == TMO_LAST) begin
          bif.bus_err   <= 1'b1;
          cache_valid   <= 1'b0;
          bif.bus_di    <= 8'hFF;
          bif.bus_ready <= 1'b1;
          state         <= GUARD;
        end else begin
          tcnt <= tcnt + 10'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bif.bus_write || bif.bus_read) begin
              lane            <= req_lane;
              wbyte           <= bif.bus_do;
              bif.mem_address <= req_word;
              tcnt            <= '0;
            end
            // a simultaneous read and write request is treated as a write
            if (bif.bus_write) begin
              if (hit) begin
                cache_data         <= merge(cache_data, req_lane, bif.bus_do);
                bif.mem_data_write <= merge(cache_data, req_lane, bif.bus_do);
                bif.mem_write      <= 1'b1;
                state              <= RMW_WR;
              end else begin
                bif.mem_read <= 1'b1;
                state        <= RMW_RD;
              end
            end else if (bif.bus_read) begin
              if (hit) begin
                bif.bus_di    <= pick(cache_data, req_lane);
                bif.bus_ready <= 1'b1;
                state         <= GUARD;
              end else begin
                bif.mem_read <= 1'b1;
                state        <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            cache_data    <= bif.mem_data_read;
            cache_tag     <= bif.mem_address;
            cache_valid   <= 1'b1;
            bif.bus_di    <= pick(bif.mem_data_read, lane);
            bif.bus_ready <= 1'b1;
            state         <= GUARD;
          end
          RMW_RD: begin
            cache_data         <= merge(bif.mem_data_read, lane, wbyte);
            cache_tag          <= bif.mem_address;
            cache_valid        <= 1'b1;
            bif.mem_data_write <= merge(bif.mem_data_read, lane, wbyte);
            bif.mem_write      <= 1'b1;
            tcnt               <= '0;
            state              <= RMW_WR;
          end
          RMW_WR: begin
            bif.bus_ready <= 1'b1;
            state         <= GUARD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
